// File: rtl/weight_pkg.sv
// rtl/weight_pkg.sv - shared constants, state encodings and config decode for the weight read path
package weight_pkg;

  localparam int NUM_BANKS = 8;

  localparam logic [10:0] WORDS_L1_M1  = 11'd63;
  localparam logic [10:0] WORDS_DEF_M1 = 11'd2047;
  localparam logic [11:0] PONG_BASE    = 12'd2048;

  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_CONFIG = 4'b0010;
  localparam logic [3:0] ST_READ   = 4'b0100;
  localparam logic [3:0] ST_DRAIN  = 4'b1000;

  typedef struct packed {
    logic [10:0] words_m1;
    logic [11:0] base;
    logic [7:0]  passes;
  } rd_cfg_t;

  // A repeat count of zero still replays the set once.
  function automatic rd_cfg_t decode_cfg(input logic [2:0] layer,
                                         input logic       half,
                                         input logic [7:0] repeat_num);
    rd_cfg_t cfg;
    cfg.words_m1 = (layer == 3'd1) ? WORDS_L1_M1 : WORDS_DEF_M1;
    cfg.base     = half ? PONG_BASE : 12'd0;
    cfg.passes   = (repeat_num == 8'd0) ? 8'd1 : repeat_num;
    return cfg;
  endfunction

endpackage

// File: rtl/weight_read_ctrl_if.sv
// rtl/weight_read_ctrl_if.sv - weight beat stream from the read controller to the PE array
interface weight_read_ctrl_if #(
  parameter int DATA_WIDTH = 64
) ();
  import weight_pkg::*;

  logic                            tvalid;
  logic                            tready;
  logic [NUM_BANKS*DATA_WIDTH-1:0] tdata;
  logic                            tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/weight_rd_fifo.sv
// rtl/weight_rd_fifo.sv - small synchronous FIFO buffering BRAM read data ahead of the stream output
module weight_rd_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH-1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Head reads as zero when empty so the stream data is clean out of reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/weight_read_ctrl.sv
// rtl/weight_read_ctrl.sv - replays one weight set from the 8 BRAM banks onto the PE-array stream
module weight_read_ctrl
  import weight_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic [2:0]                      layer_i,
  input  logic                            half_i,
  input  logic [7:0]                      repeat_num_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            half_release_o,
  output logic                            bram_en_o,
  output logic [11:0]                     bram_addr_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bram_rdata_i,
  weight_read_ctrl_if.master              m_axis
);
  localparam int DW = NUM_BANKS*DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [3:0]        state_q, state_d;
  rd_cfg_t           cfg_q, cfg_d;
  logic [10:0]       addr_cnt_q, addr_cnt_d;
  logic [7:0]        pass_cnt_q, pass_cnt_d;
  logic [RD_LAT-1:0] vld_q, last_q;
  logic              done_q;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  logic [DW:0]       fifo_rdata;
  logic [CW:0]       inflight, credit_used;
  logic              issue, last_issue, final_issue, pop, final_accept;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + {{CW{1'b0}}, vld_q[i]};
  end

  // Credit covers both buffered beats and reads still inside the BRAM pipeline.
  assign credit_used  = {1'b0, fifo_count} + inflight;
  assign issue        = (state_q == ST_READ) && !fifo_full && (credit_used < DEPTH_C);
  assign last_issue   = (addr_cnt_q == cfg_q.words_m1);
  assign final_issue  = issue && last_issue && (pass_cnt_q == cfg_q.passes - 8'd1);
  assign pop          = m_axis.tvalid && m_axis.tready;
  assign final_accept = (state_q == ST_DRAIN) && pop && m_axis.tlast &&
                        (fifo_count == CW'(1)) && (inflight == '0);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    addr_cnt_d = addr_cnt_q;
    pass_cnt_d = pass_cnt_q;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_CONFIG;
      ST_CONFIG: begin
        cfg_d      = decode_cfg(layer_i, half_i, repeat_num_i);
        addr_cnt_d = '0;
        pass_cnt_d = '0;
        state_d    = ST_READ;
      end
      ST_READ:   if (final_issue) state_d = ST_DRAIN;
      ST_DRAIN:  if (final_accept) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (issue) begin
      if (last_issue) begin
        addr_cnt_d = '0;
        pass_cnt_d = pass_cnt_q + 8'd1;
      end else begin
        addr_cnt_d = addr_cnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      addr_cnt_q <= '0;
      pass_cnt_q <= '0;
      vld_q      <= '0;
      last_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      addr_cnt_q <= addr_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      vld_q[0]   <= issue;
      last_q[0]  <= last_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
      done_q     <= final_accept;
    end
  end

  weight_rd_fifo #(
    .WIDTH (DW+1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vld_q[RD_LAT-1]),
    .wdata_i ({last_q[RD_LAT-1], bram_rdata_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign m_axis.tvalid  = !fifo_empty;
  assign m_axis.tdata   = fifo_rdata[DW-1:0];
  assign m_axis.tlast   = fifo_rdata[DW];

  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = done_q;
  assign half_release_o = done_q;
  assign bram_en_o      = issue;
  assign bram_addr_o    = issue ? (cfg_q.base + {1'b0, addr_cnt_q}) : 12'd0;

endmodule

// File: tb/tb_weight_read_ctrl.sv
// tb/tb_weight_read_ctrl.sv - directed vector bench for weight_read_ctrl with a behavioural BRAM
module tb_weight_read_ctrl;
  localparam int DW     = 64;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    layer;
  logic          half;
  logic [7:0]    repeat_num;
  logic          busy, done, half_release, bram_en;
  logic [11:0]   bram_addr;
  logic [8*DW-1:0] bram_rdata;
  logic [11:0]   rd_addr_pipe [RD_LAT];

  weight_read_ctrl_if #(.DATA_WIDTH(DW)) axis_if ();

  weight_read_ctrl #(.DATA_WIDTH(DW), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .layer_i        (layer),
    .half_i         (half),
    .repeat_num_i   (repeat_num),
    .busy_o         (busy),
    .done_o         (done),
    .half_release_o (half_release),
    .bram_en_o      (bram_en),
    .bram_addr_o    (bram_addr),
    .bram_rdata_i   (bram_rdata),
    .m_axis         (axis_if)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bank_word(input int k, input logic [11:0] a);
    return {32'(k), 20'h0, a};
  endfunction

  always_ff @(posedge clk) begin
    if (bram_en) rd_addr_pipe[0] <= bram_addr;
    for (int j = 1; j < RD_LAT; j++) rd_addr_pipe[j] <= rd_addr_pipe[j-1];
  end

  always_comb begin
    bram_rdata = '0;
    for (int k = 0; k < 8; k++) bram_rdata[k*DW +: DW] = bank_word(k, rd_addr_pipe[RD_LAT-1]);
  end

  typedef struct {
    logic [2:0]  layer;
    logic        half;
    logic [7:0]  rep;
    bit          rand_ready;
    int          repulse_cyc;
    int          exp_beats;
    int          exp_words;
    logic [11:0] exp_base;
    int          exp_cycles;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_xfer(input string tag, input vec_t v);
    int cyc, issues, beats, done_cnt, done_cyc, first_en, first_v, outstanding, max_out, limit;
    int addr_errs, data_errs, last_errs, stall_errs, busy_errs, hr_errs, idx;
    logic [11:0] exp_addr;
    logic [8*DW-1:0] prev_data;
    logic prev_last, prev_stall;
    issues = 0; beats = 0; done_cnt = 0; done_cyc = -1; first_en = -1; first_v = -1;
    outstanding = 0; max_out = 0; addr_errs = 0; data_errs = 0; last_errs = 0;
    stall_errs = 0; busy_errs = 0; hr_errs = 0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    limit = v.exp_beats * 4 + 100;
    layer = v.layer; half = v.half; repeat_num = v.rep; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < limit) begin
      axis_if.tready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (cyc == v.repulse_cyc);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done != half_release) hr_errs++;
      if (busy != (done_cyc < 0)) busy_errs++;
      if (bram_en) begin
        if (first_en < 0) first_en = cyc;
        if (bram_addr != v.exp_base + 12'(issues % v.exp_words)) addr_errs++;
        issues++;
        outstanding++;
      end
      if (prev_stall && (!axis_if.tvalid || axis_if.tdata != prev_data || axis_if.tlast != prev_last))
        stall_errs++;
      if (axis_if.tvalid && first_v < 0) first_v = cyc;
      if (axis_if.tvalid && axis_if.tready) begin
        idx = beats % v.exp_words;
        exp_addr = v.exp_base + 12'(idx);
        for (int k = 0; k < 8; k++)
          if (axis_if.tdata[k*DW +: DW] != bank_word(k, exp_addr)) data_errs++;
        if (axis_if.tlast != (idx == v.exp_words - 1)) last_errs++;
        beats++;
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      prev_stall = axis_if.tvalid && !axis_if.tready;
      prev_data  = axis_if.tdata;
      prev_last  = axis_if.tlast;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, longint'(done_cyc >= 0), 1);
    check({tag, "_beats"}, beats, v.exp_beats);
    check({tag, "_issues"}, issues, v.exp_beats);
    check({tag, "_addr_errs"}, addr_errs, 0);
    check({tag, "_data_errs"}, data_errs, 0);
    check({tag, "_tlast_errs"}, last_errs, 0);
    check({tag, "_stall_errs"}, stall_errs, 0);
    check({tag, "_busy_errs"}, busy_errs, 0);
    check({tag, "_half_release_errs"}, hr_errs, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_credit_ok"}, longint'(max_out <= DEPTH), 1);
    if (!v.rand_ready) begin
      check({tag, "_done_cycle"}, done_cyc, v.exp_cycles);
      check({tag, "_first_en_cycle"}, first_en, 2);
      check({tag, "_first_tvalid_cycle"}, first_v, 3 + RD_LAT);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int beats, guard, errs;
    vec_t clean;
    vecs[0] = '{3'd1, 1'b0, 8'd1, 1'b0, 0,  64,   64,   12'd0,    68};
    vecs[1] = '{3'd2, 1'b1, 8'd2, 1'b0, 0,  4096, 2048, 12'd2048, 4100};
    vecs[2] = '{3'd1, 1'b0, 8'd1, 1'b1, 0,  64,   64,   12'd0,    0};
    vecs[3] = '{3'd1, 1'b1, 8'd0, 1'b0, 0,  64,   64,   12'd2048, 68};
    vecs[4] = '{3'd1, 1'b0, 8'd3, 1'b1, 0,  192,  64,   12'd0,    0};
    vecs[5] = '{3'd1, 1'b0, 8'd1, 1'b0, 10, 64,   64,   12'd0,    68};

    rst = 1'b1; start = 1'b0; layer = 3'd1; half = 1'b0; repeat_num = 8'd1;
    axis_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ctrl_outputs", {busy, done, half_release, bram_en, axis_if.tvalid, axis_if.tlast}, 0);
    check("reset_bram_addr", bram_addr, 0);
    check("reset_tdata_zero", longint'(axis_if.tdata == '0), 1);

    for (int i = 0; i < 6; i++) begin
      run_xfer($sformatf("v%0d", i), vecs[i]);
      @(posedge clk); #1;
    end

    layer = 3'd1; half = 1'b0; repeat_num = 8'd1; axis_if.tready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0; guard = 0;
    while (beats < 30 && guard < 200) begin
      if (axis_if.tvalid) beats++;
      @(posedge clk); #1;
      guard++;
    end
    check("midrst_reached_beat30", beats, 30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ctrl_outputs", {busy, done, half_release, bram_en, axis_if.tvalid, axis_if.tlast}, 0);
    check("midrst_bram_addr", bram_addr, 0);
    check("midrst_tdata_zero", longint'(axis_if.tdata == '0), 1);
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || half_release || busy || bram_en || axis_if.tvalid) errs++;
      @(posedge clk); #1;
    end
    check("midrst_quiet_after", errs, 0);
    clean = '{3'd1, 1'b0, 8'd1, 1'b0, 0, 64, 64, 12'd0, 68};
    run_xfer("post_rst", clean);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_read_ctrl.md
# weight_read_ctrl

Reads one weight set back out of the 8 weight BRAM banks and streams it to the PE array, one 8-bank-wide word per beat. It sits directly downstream of the weight write stage, which fills banks 0–7 in ping (base 0) or pong (base 2048) halves. The block can replay a set multiple times for output-channel reuse. It releases the half back to the writer when the final pass has been consumed.

## Interface
Parameters:
- DATA_WIDTH, 64, width of one bank word
- RD_LAT, 1, BRAM read latency in cycles (1 or 2)
- FIFO_DEPTH, 4, output buffer depth; must be ≥ RD_LAT+2

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- layer  in  3  layer 1 → 64 words/bank; any other value → 2048 words/bank
- half  in  1  0 → base address 0; 1 → base address 2048
- repeat_num  in  8  number of passes over the set; 0 is treated as 1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final beat is accepted
- half_release  out  1  one-cycle pulse, coincident with done
- bram_en  out  1  read enable, shared by all 8 banks
- bram_addr  out  12  read address, shared by all 8 banks
- bram_rdata  in  8*DATA_WIDTH  bank k data on [k*DATA_WIDTH +: DATA_WIDTH]
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  8*DATA_WIDTH  bank k data on [k*DATA_WIDTH +: DATA_WIDTH]
- m_axis_tlast  out  1  marks the last beat of each pass

## Operation
- FSM states: IDLE, CONFIG, READ, DRAIN (one-hot).
- IDLE → CONFIG on start.
- CONFIG latches the following, then goes to READ:
  - words_m1: 63 or 2047, selected by layer
  - base: half ? 2048 : 0
  - passes: max(repeat_num, 1)
- READ → DRAIN when the last read of the last pass is issued.
- DRAIN → IDLE when the final tlast beat is accepted, the FIFO is empty and nothing is in flight.
- Read issue condition: state==READ and (fifo_count + inflight) < FIFO_DEPTH.
  - On issue: bram_en=1, bram_addr = base + addr_cnt.
  - addr_cnt (11 bit) counts 0..words_m1, then wraps to 0 and increments pass_cnt (8 bit).
- In-flight tracking:
  - A RD_LAT-deep shift register carries {valid, last}.
  - last = (addr_cnt == words_m1) at issue time.
  - On exit, bram_rdata and the last tag are written into the FIFO.
- Output side:
  - m_axis_tvalid = FIFO non-empty; tdata and tlast come from the FIFO head.
  - A pop happens on tvalid && tready.
  - tdata and tlast hold stable while tvalid is high and tready is low.
- Final beat: on acceptance of the last tlast of pass passes-1, done and half_release pulse on the next cycle, and the state returns to IDLE.
- Boundary rules:
  - start outside IDLE is ignored.
  - Simultaneous FIFO push and pop leaves the count unchanged.
  - The credit rule guarantees the FIFO never overflows; a push into a full FIFO is a design error, and the verifier asserts on it.
  - addr_cnt wrap and pass increment occur in the same cycle as the issue of the words_m1 read.
  - Reset mid-operation returns to IDLE, empties the FIFO and the in-flight register, and produces no done pulse.

## Timing
- Reset values: busy, done, half_release, bram_en, m_axis_tvalid and m_axis_tlast are 0; bram_addr is 0; m_axis_tdata is 0.
- start sampled at edge 0; CONFIG in cycle 1; first bram_en in cycle 2.
- Data is pushed into the FIFO at the end of cycle 2+RD_LAT; m_axis_tvalid rises in cycle 3+RD_LAT.
- With tready held high: one beat per cycle, no bubbles, including across pass boundaries.
- Total cycles from start to done (tready=1): words × passes + RD_LAT + 3.
- Backpressure: reads stop within one cycle of the FIFO credit being exhausted and resume the cycle after a pop frees space.

## Structure
- Shared package (weight_pkg) holds:
  - the FSM state encodings
  - WORDS_L1_M1=63 and WORDS_DEF_M1=2047
  - PONG_BASE=2048
  - the bank count, 8
- Sub-module weight_rd_fifo: synchronous FIFO, width 8*DATA_WIDTH+1, depth FIFO_DEPTH.
  - Ports: push, pop, count, empty, full, with same-cycle push/pop supported.
- Top level holds the FSM, the counters and the in-flight shift register.

## Test plan
- layer=1, half=0, repeat_num=1, tready=1:
  - 64 beats; bram_addr 0..63
  - bank k of beat i equals the preloaded value {k,i}
  - tlast only on beat 64
  - done at cycle 64+RD_LAT+3
- layer=2, half=1, repeat_num=2:
  - addresses run 2048..4095 twice
  - 4096 beats, with tlast on beats 2048 and 4096
  - a single done pulse, with half_release coincident
- layer=1, random tready (50%):
  - beat order and data are intact
  - tdata stable while stalled
  - FIFO never overflows; inflight+count ≤ FIFO_DEPTH always
- repeat_num=0: behaves as one pass of 64 beats.
- start re-pulsed during READ is ignored, and the beat count is unchanged.
- rst asserted at beat 30 of layer 1:
  - next cycle: all outputs at reset values, no done
  - a new start then produces a clean 64-beat pass from address 0.
